sr_ff_excitation_driver: RTL and testbench
==========================================

// Module: sr_ff_excitation_driver
// PURPOSE
//  Transmit side of the SR flip-flop interface. Accepts a WIDTH-bit target word over valid/ready.
//  Serialises it LSB first and drives s/r per the SR excitation table, so the downstream SR ff's q
//  follows the bit sequence. Never issues s=r=1. Checks q/qbar feedback after each bit; flags mismatches.
// PARAMETERS
//  WIDTH     8  bits per accepted word, >=2
//  EXPLICIT  0  1: drive s or r on every bit (no hold cycles); 0: hold (s=r=0) when target==model
//  IDX_W     localparam = $clog2(WIDTH); width of bit index/err_idx
// PORTS
//  clk       in   1      single clock, all state on posedge
//  rst       in   1      synchronous, active-high reset
//  in_valid  in   1      target word offered
//  in_ready  out  1      driver idle, word accepted on clk edge when in_valid&&in_ready
//  in_data   in   WIDTH  target q sequence, bit 0 applied first
//  s         out  1      set command to SR ff (registered)
//  r         out  1      reset command to SR ff (registered)
//  q_fb      in   1      SR ff q
//  qbar_fb   in   1      SR ff qbar
//  busy      out  1      word in progress
//  done      out  1      one-cycle pulse: last bit of word checked
//  err       out  1      sticky mismatch flag, cleared only by rst
//  err_idx   out  IDX_W  bit index of first mismatch since rst
// BEHAVIOUR
//  Reset: s=0 r=0 busy=0 done=0 err=0 err_idx=0 in_ready=1; shift reg/counter cleared; known=0.
//  State: IDLE -> DRIVE -> SETTLE -> (DRIVE next bit | IDLE after bit WIDTH-1).
//  IDLE: in_ready=1, s=r=0. Handshake at edge E0 loads shift reg, idx=0, goes DRIVE.
//  DRIVE (1 cycle): d=current bit; qm=internal model of ff q; known=model valid.
//   - known=0 or EXPLICIT=1: s=d, r=~d.
//   - else d==qm: s=r=0 (hold); d=1,qm=0: s=1; d=0,qm=1: r=1.
//   - s&&r is never 1 in any cycle, any state, including reset.
//  SETTLE (1 cycle): s=r=0. The ff samples s/r at the edge ending DRIVE.
//   At the edge ending SETTLE, sample the feedback: mismatch if q_fb!=d or qbar_fb!=~d.
//   - match: qm<=d, known<=1.
//   - mismatch: known<=0, so the next bit is explicit; err<=1; err_idx<=idx if err was 0.
//   - idx<WIDTH-1: idx++, shift, DRIVE. Else IDLE, done=1 in the following cycle.
//  Latency: bit k s/r valid in cycle 2k+1 after E0; last check at edge E0+2*WIDTH.
//   done and in_ready are both high in cycle 2*WIDTH+1. Back-to-back accept is allowed in that cycle.
//  busy=1 in DRIVE/SETTLE; in_ready=0 while busy; in_valid ignored while busy.
//  known persists across words (qm carries over); only rst or a mismatch clears it.
//  rst mid-word: abort immediately. Next cycle s=r=0, IDLE, word discarded, err cleared.
//  No done for the aborted word.
//  Feedback X/Z (uninitialised ff) counts as mismatch in simulation; the bench compares with !==.
// STRUCTURE
//  sr_ff_defs.vh (shared include): state encodings IDLE/DRIVE/SETTLE; excitation codes HOLD/SET/RST.
//  Sub-module sr_ff_excitation_enc (combinational): (d, qm, known, EXPLICIT) -> {s_nxt, r_nxt}.
//   Reused by future JK/T drivers' checkers.
//  Top: FSM, WIDTH shift reg, IDX_W counter, model regs, error capture.
// TESTING (WIDTH=8, DUT drives the codebase SR ff behavioural model unless stated)
//  1 rst, send 8'hA5: bit0 explicit s=1; s/r per table; done at cycle 17 after E0; err=0; ff q = bits.
//  2 8'hFF then 8'hFF: second word all 8 DRIVE cycles s=r=0 (hold); done, err=0.
//  3 1000 random words with random in_valid gaps: assertion !(s&&r) every cycle; err stays 0.
//  4 q_fb stuck 0 (fault model), send 8'h0F: err=1 at bit0 check, err_idx=0.
//    Bit1 driven explicit; err_idx unchanged at bits 1-3.
//  5 rst asserted in cycle 5 of word 8'h3C: next cycle s=r=0, busy=0, in_ready=1, err=0, no done.
//  6 in_valid held high with 8'h12 then 8'h34: 8'h34 accepted exactly at the cycle done=1 for 8'h12.
//    No word is lost or duplicated.

Source files
------------

// File: rtl/sr_ff_excitation_driver_pkg.sv
// ---------------------------------------------------------------------------
// sr_ff_excitation_driver_pkg
//   Shared definitions for the SR flip-flop transmit driver and the excitation
//   encoder: FSM state encodings and the {s,r} excitation codes.
// ---------------------------------------------------------------------------
package sr_ff_excitation_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    // Bit 1 is s, bit 0 is r; the 2'b11 pattern is deliberately absent.
    typedef enum logic [1:0] {
        EXC_HOLD = 2'b00,
        EXC_RST  = 2'b01,
        EXC_SET  = 2'b10
    } exc_e;

endpackage

// File: rtl/sr_ff_excitation_enc.sv
// ---------------------------------------------------------------------------
// sr_ff_excitation_enc
//   Combinational SR excitation encoder. Given the wanted next q (d_i), the
//   modelled current q (qm_i) and whether that model is trustworthy
//   (known_i), produces the s/r pair. When the model is unknown, or when
//   EXPLICIT is set, the bit is always forced explicitly.
//   Ports:
//     d_i      in  1  wanted flip-flop state
//     qm_i     in  1  modelled flip-flop state
//     known_i  in  1  qm_i is valid
//     s_nxt_o  out 1  set command
//     r_nxt_o  out 1  reset command (never high together with s_nxt_o)
// ---------------------------------------------------------------------------
module sr_ff_excitation_enc
    import sr_ff_excitation_driver_pkg::*;
#(
    parameter bit EXPLICIT = 1'b0
) (
    input  logic d_i,
    input  logic qm_i,
    input  logic known_i,
    output logic s_nxt_o,
    output logic r_nxt_o
);

    exc_e code;

    always_comb begin
        code = EXC_HOLD;
        if (!known_i || EXPLICIT) begin
            code = d_i ? EXC_SET : EXC_RST;
        end else if (d_i && !qm_i) begin
            code = EXC_SET;
        end else if (!d_i && qm_i) begin
            code = EXC_RST;
        end
    end

    assign s_nxt_o = code[1];
    assign r_nxt_o = code[0];

endmodule

// File: rtl/sr_ff_excitation_driver.sv
// ---------------------------------------------------------------------------
// sr_ff_excitation_driver
//   Transmit side of an SR flip-flop link. Accepts a WIDTH-bit target word
//   over valid/ready, walks it LSB first and drives registered s/r so the
//   downstream SR flip-flop's q follows the bits. Each bit takes two cycles:
//   DRIVE (s/r asserted) then SETTLE (s=r=0, feedback sampled at its end).
//   Mismatching feedback raises a sticky err and records the first bad index.
//   Ports:
//     clk       in  1      clock, all state on posedge
//     rst       in  1      synchronous active-high reset
//     in_valid  in  1      target word offered
//     in_ready  out 1      idle, word accepted when in_valid && in_ready
//     in_data   in  WIDTH  target bit sequence, bit 0 first
//     s, r      out 1      registered SR commands (never both high)
//     q_fb      in  1      flip-flop q
//     qbar_fb   in  1      flip-flop qbar
//     busy      out 1      word in progress
//     done      out 1      one-cycle pulse after the last bit is checked
//     err       out 1      sticky mismatch flag
//     err_idx   out IDX_W  index of the first mismatching bit
// ---------------------------------------------------------------------------
module sr_ff_excitation_driver
    import sr_ff_excitation_driver_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  bit EXPLICIT = 1'b0,
    localparam int IDX_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             s,
    output logic             r,
    input  logic             q_fb,
    input  logic             qbar_fb,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [IDX_W-1:0] err_idx
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               qm_q, qm_d;
    logic               known_q, known_d;
    logic               s_q, r_q;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   err_idx_q, err_idx_d;

    logic               cur_bit;
    logic               fb_ok;
    logic               enc_bit;
    logic               enc_s, enc_r;
    logic               s_d, r_d;

    assign cur_bit = shift_q[0];
    // An X/Z feedback makes fb_ok unknown, which the if below treats as a mismatch.
    assign fb_ok   = (q_fb == cur_bit) && (qbar_fb == ~cur_bit);

    // s/r are registered, so the encoder looks one cycle ahead: the bit about
    // to enter DRIVE, against the model as it will be after this edge.
    assign enc_bit = (state_q == ST_IDLE) ? in_data[0] : shift_q[1];

    sr_ff_excitation_enc #(
        .EXPLICIT (EXPLICIT)
    ) u_enc (
        .d_i     (enc_bit),
        .qm_i    (qm_d),
        .known_i (known_d),
        .s_nxt_o (enc_s),
        .r_nxt_o (enc_r)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        qm_d      = qm_q;
        known_d   = known_q;
        done_d    = 1'b0;
        err_d     = err_q;
        err_idx_d = err_idx_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shift_d = in_data;
                    idx_d   = '0;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (fb_ok) begin
                    qm_d    = cur_bit;
                    known_d = 1'b1;
                end else begin
                    // Forget the model so the next bit is forced explicitly.
                    known_d = 1'b0;
                    err_d   = 1'b1;
                    if (!err_q) begin
                        err_idx_d = idx_q;
                    end
                end
                if (idx_q == IDX_W'(WIDTH - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    shift_d = shift_q >> 1;
                    state_d = ST_DRIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        s_d = (state_d == ST_DRIVE) && enc_s;
        r_d = (state_d == ST_DRIVE) && enc_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            idx_q     <= '0;
            qm_q      <= 1'b0;
            known_q   <= 1'b0;
            s_q       <= 1'b0;
            r_q       <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            qm_q      <= qm_d;
            known_q   <= known_d;
            s_q       <= s_d;
            r_q       <= r_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign s        = s_q;
    assign r        = r_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_idx  = err_idx_q;

endmodule

// File: tb/tb_sr_ff_excitation_driver.sv
// ---------------------------------------------------------------------------
// tb_sr_ff_excitation_driver
//   Directed bench for sr_ff_excitation_driver (WIDTH=8, EXPLICIT=0) driving
//   a behavioural SR flip-flop. Inputs change and outputs are sampled on the
//   falling clock edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_sr_ff_excitation_driver;

    localparam int W = 8;

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data  = '0;
    logic         in_ready;
    logic         s, r;
    logic         q_fb, qbar_fb;
    logic         busy, done, err;
    logic [2:0]   err_idx;

    logic         ffq   = 1'b0;
    logic         stuck = 1'b0;

    int errors  = 0;
    int checks  = 0;
    int sr_viol = 0;
    int hs_cnt  = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    // Behavioural SR flip-flop; q_fb can be forced to a stuck-at-0 fault.
    always @(posedge clk) begin
        if (s)      ffq <= 1'b1;
        else if (r) ffq <= 1'b0;
    end
    assign q_fb    = stuck ? 1'b0 : ffq;
    assign qbar_fb = ~ffq;

    always @(negedge clk) begin
        if (s && r) sr_viol <= sr_viol + 1;
    end

    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) hs_cnt <= hs_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    sr_ff_excitation_driver #(
        .WIDTH    (W),
        .EXPLICIT (1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .s        (s),
        .r        (r),
        .q_fb     (q_fb),
        .qbar_fb  (qbar_fb),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_idx  (err_idx)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", in_ready, 1);
    endtask

    // Sends one word and checks every cycle of it: s/r in each DRIVE cycle,
    // s=r=0 and the flip-flop state in each SETTLE cycle, err after each bit's
    // check, and done/in_ready only in cycle 17.
    task automatic drive_word(input logic [W-1:0] w, input logic [W-1:0] es,
                              input logic [W-1:0] er, input logic [W-1:0] eerr,
                              input bit chk_q, input string tag);
        @(negedge clk);
        wait_ready();
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < W; k++) begin
            chk($sformatf("%s_s%0d", tag, k), s, es[k]);
            chk($sformatf("%s_r%0d", tag, k), r, er[k]);
            chk($sformatf("%s_busy%0d", tag, k), busy, 1);
            @(negedge clk);
            chk($sformatf("%s_settle_sr%0d", tag, k), {s, r}, 2'b00);
            if (chk_q) chk($sformatf("%s_q%0d", tag, k), ffq, w[k]);
            @(negedge clk);
            chk($sformatf("%s_err%0d", tag, k), err, eerr[k]);
            chk($sformatf("%s_done%0d", tag, k), done, (k == W - 1));
            chk($sformatf("%s_ready%0d", tag, k), in_ready, (k == W - 1));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int h0, d0, v0, dc;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_s", s, 0);
        chk("rst_r", r, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_idx", err_idx, 0);
        chk("rst_ready", in_ready, 1);

        // A5 = bits 1,0,1,0,0,1,0,1: S R S R H S R S
        drive_word(8'hA5, 8'hA5, 8'h4A, 8'h00, 1'b1, "a5");
        @(negedge clk);
        chk("a5_done_pulse", done, 0);

        // FF twice: first bit explicit, everything after holds
        do_reset();
        drive_word(8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, "ff1");
        drive_word(8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, "ff2");

        // q_fb stuck at 0, word 0F: bits 0-3 mismatch and stay explicit,
        // bit 4 explicit reset matches, bits 5-7 hold
        do_reset();
        stuck = 1'b1;
        drive_word(8'h0F, 8'h0F, 8'h10, 8'hFF, 1'b0, "stuck");
        chk("stuck_err_idx", err_idx, 0);
        chk("stuck_err", err, 1);
        stuck = 1'b0;

        // Abort word 3C with rst in cycle 5; err from the previous word is still set
        @(negedge clk);
        wait_ready();
        in_valid = 1'b1;
        in_data  = 8'h3C;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_sr", {s, r}, 2'b00);
        chk("abort_busy", busy, 0);
        chk("abort_ready", in_ready, 1);
        chk("abort_err", err, 0);
        chk("abort_done", done, 0);
        dc = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dc++;
        end
        chk("abort_no_done", dc, 0);

        // in_valid held across two words: 34 accepted in the done cycle of 12
        do_reset();
        @(negedge clk);
        h0 = hs_cnt;
        in_valid = 1'b1;
        in_data  = 8'h12;
        @(negedge clk);
        in_data  = 8'h34;
        chk("b2b_hs_first", hs_cnt - h0, 1);
        repeat (15) @(negedge clk);
        chk("b2b_done16", done, 0);
        @(negedge clk);
        chk("b2b_done17", done, 1);
        chk("b2b_ready17", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_busy_second", busy, 1);
        chk("b2b_hs_second", hs_cnt - h0, 2);
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_q%0d", k), ffq, in_data[k]);
            @(negedge clk);
        end
        chk("b2b_done_second", done, 1);
        chk("b2b_hs_total", hs_cnt - h0, 2);

        // 1000 random words with random idle gaps
        do_reset();
        v0 = sr_viol;
        d0 = done_cnt;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            wait_ready();
            in_valid = 1'b1;
            in_data  = W'($urandom);
            @(negedge clk);
            in_valid = 1'b0;
        end
        wait_ready();
        repeat (2) @(negedge clk);
        chk("rand_sr_never_both", sr_viol - v0, 0);
        chk("rand_err", err, 0);
        chk("rand_done_count", done_cnt - d0, 1000);
        chk("all_sr_never_both", sr_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
